// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Holds the fetch PC, issues in-order
//            requests to instruction memory (req/gnt + rvalid), buffers up to
//            two returned instructions with their PCs, pre-decodes the
//            immediate class of the head and handles branch/jump redirects
//            by dropping responses that were already in flight.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   // Instruction memory side
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemGnt,
   input  logic        imemRvalid,
   input  logic [31:0] imemRdata,
   // Control flow redirect
   input  logic        redirect,
   input  logic [31:0] redirectPc,
   // Decode side
   output logic        instrValid,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [1:0]  immSrc,
   input  logic        decReady
);

   localparam logic [31:0] c_NOP       = 32'h0000_0013;
   localparam logic [31:0] c_ALIGN     = 32'hFFFF_FFFC;
   localparam logic [31:0] c_START_PC  = RESET_PC & c_ALIGN;
   localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
   localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  c_OP_JAL    = 7'b1101111;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic        r_active;       // low until the first clock after reset
   logic [31:0] r_fetchPc;      // address of the next request
   logic [31:0] r_respPc;       // PC belonging to the next accepted response
   logic [1:0]  r_outstanding;  // granted requests not yet answered
   logic [1:0]  r_dropCount;    // stale responses still to be discarded

   // Two-entry shift FIFO; slot 0 is always the head so the decode outputs
   // can be driven straight from flops. An empty head slot holds NOP / PC 0.
   logic        r_v0;
   logic        r_v1;
   logic [31:0] r_pc0;
   logic [31:0] r_pc1;
   logic [31:0] r_instr0;
   logic [31:0] r_instr1;

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------
   logic        w_pop;
   logic        w_push;
   logic        w_drop;
   logic        w_gnt;
   logic [1:0]  w_occ;
   logic [2:0]  w_credit;
   logic [1:0]  w_outRetired;
   logic [31:0] w_redirectPc;

   logic        w_v0_n;
   logic        w_v1_n;
   logic [31:0] w_pc0_n;
   logic [31:0] w_pc1_n;
   logic [31:0] w_instr0_n;
   logic [31:0] w_instr1_n;

   assign w_pop        = r_v0 & decReady;
   assign w_occ        = {1'b0, r_v0} + {1'b0, r_v1};
   // Slots committed next cycle: in-flight requests plus buffered entries,
   // less the one decode is taking right now.
   assign w_credit     = {1'b0, r_outstanding} + {1'b0, w_occ} - {2'b00, w_pop};
   assign imemReq      = r_active & ~redirect & (w_credit < 3'd2);
   assign imemAddr     = r_fetchPc;
   assign w_gnt        = imemReq & imemGnt;
   assign w_drop       = imemRvalid & (r_dropCount != 2'd0);
   assign w_push       = imemRvalid & (r_dropCount == 2'd0) & ~redirect;
   assign w_outRetired = r_outstanding - {1'b0, imemRvalid};
   assign w_redirectPc = redirectPc & c_ALIGN;

   assign instrValid   = r_v0;
   assign instr        = r_instr0;
   assign pc           = r_pc0;

   // Next FIFO contents from the push/pop combination; redirect flushes.
   always_comb begin
      w_v0_n     = r_v0;
      w_v1_n     = r_v1;
      w_pc0_n    = r_pc0;
      w_pc1_n    = r_pc1;
      w_instr0_n = r_instr0;
      w_instr1_n = r_instr1;
      if (redirect) begin
         w_v0_n     = 1'b0;
         w_v1_n     = 1'b0;
         w_pc0_n    = 32'h0;
         w_pc1_n    = 32'h0;
         w_instr0_n = c_NOP;
         w_instr1_n = c_NOP;
      end else begin
         case ({w_pop, w_push})
            2'b11: begin
               if (r_v1) begin
                  w_pc0_n    = r_pc1;
                  w_instr0_n = r_instr1;
                  w_pc1_n    = r_respPc;
                  w_instr1_n = imemRdata;
               end else begin
                  w_pc0_n    = r_respPc;
                  w_instr0_n = imemRdata;
               end
            end
            2'b10: begin
               if (r_v1) begin
                  w_pc0_n    = r_pc1;
                  w_instr0_n = r_instr1;
               end else begin
                  w_v0_n     = 1'b0;
                  w_pc0_n    = 32'h0;
                  w_instr0_n = c_NOP;
               end
               w_v1_n     = 1'b0;
               w_pc1_n    = 32'h0;
               w_instr1_n = c_NOP;
            end
            2'b01: begin
               if (!r_v0) begin
                  w_v0_n     = 1'b1;
                  w_pc0_n    = r_respPc;
                  w_instr0_n = imemRdata;
               end else begin
                  w_v1_n     = 1'b1;
                  w_pc1_n    = r_respPc;
                  w_instr1_n = imemRdata;
               end
            end
            default: ;
         endcase
      end
   end

   // Immediate class of the head instruction from its opcode.
   always_comb begin
      immSrc = 2'b00;
      case (r_instr0[6:0])
         c_OP_STORE:  immSrc = 2'b01;
         c_OP_BRANCH: immSrc = 2'b10;
         c_OP_JAL:    immSrc = 2'b11;
         default:     immSrc = 2'b00;
      endcase
   end

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------

   // Fetch pointer, response pointer and the outstanding/drop bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active      <= 1'b0;
         r_fetchPc     <= c_START_PC;
         r_respPc      <= c_START_PC;
         r_outstanding <= 2'd0;
         r_dropCount   <= 2'd0;
      end else begin
         r_active      <= 1'b1;
         r_outstanding <= w_outRetired + {1'b0, w_gnt};
         if (redirect) begin
            r_fetchPc   <= w_redirectPc;
            r_respPc    <= w_redirectPc;
            // Everything still in flight after this cycle is stale.
            r_dropCount <= w_outRetired;
         end else begin
            if (w_gnt) begin
               r_fetchPc <= r_fetchPc + 32'd4;
            end
            if (w_push) begin
               r_respPc <= r_respPc + 32'd4;
            end
            r_dropCount <= r_dropCount - {1'b0, w_drop};
         end
      end
   end

   // Instruction buffer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v0     <= 1'b0;
         r_v1     <= 1'b0;
         r_pc0    <= 32'h0;
         r_pc1    <= 32'h0;
         r_instr0 <= c_NOP;
         r_instr1 <= c_NOP;
      end else begin
         r_v0     <= w_v0_n;
         r_v1     <= w_v1_n;
         r_pc0    <= w_pc0_n;
         r_pc1    <= w_pc1_n;
         r_instr0 <= w_instr0_n;
         r_instr1 <= w_instr1_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with a behavioural
//            instruction memory of selectable 1- or 2-cycle response latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemGnt;
   logic        imemRvalid;
   logic [31:0] imemRdata;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        instrValid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [1:0]  immSrc;
   logic        decReady;

   int errors = 0;
   int checks = 0;

   fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
      .clk        (clk),
      .rst        (rst),
      .imemReq    (imemReq),
      .imemAddr   (imemAddr),
      .imemGnt    (imemGnt),
      .imemRvalid (imemRvalid),
      .imemRdata  (imemRdata),
      .redirect   (redirect),
      .redirectPc (redirectPc),
      .instrValid (instrValid),
      .instr      (instr),
      .pc         (pc),
      .immSrc     (immSrc),
      .decReady   (decReady)
   );

   always #5 clk = ~clk;

   // Memory image: a few fixed words for the immediate-class checks,
   // otherwise an I-type word derived from the address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      case (a)
         32'h0000_0300: memf = 32'h00A0_0093;
         32'h0000_0304: memf = 32'h0011_2023;
         32'h0000_0308: memf = 32'h0000_0463;
         32'h0000_030C: memf = 32'h0080_006F;
         32'h0000_0310: memf = 32'h0000_0037;
         default:       memf = {a[24:0], 7'h13};
      endcase
   endfunction

   // Memory responder: response one or two cycles after the grant.
   logic        lat2;
   logic        s1v, s2v;
   logic [31:0] s1d, s2d;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         s1v <= 1'b0;
         s2v <= 1'b0;
         s1d <= 32'h0;
         s2d <= 32'h0;
      end else begin
         s1v <= imemReq & imemGnt;
         s1d <= memf(imemAddr);
         s2v <= s1v;
         s2d <= s1d;
      end
   end
   assign imemRvalid = lat2 ? s2v : s1v;
   assign imemRdata  = lat2 ? s2d : s1d;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a valid head and check it; decReady stays high so
   // each head is consumed on the following edge.
   task automatic wait_head(input string tag, input logic [31:0] ep,
                            input logic [31:0] ei, input logic [1:0] es);
      int n = 0;
      do begin
         step();
         n++;
      end while (!instrValid && n < 12);
      chk({tag, "_valid"}, {31'b0, instrValid}, 32'd1);
      chk({tag, "_pc"}, pc, ep);
      chk({tag, "_instr"}, instr, ei);
      chk({tag, "_imm"}, {30'b0, immSrc}, {30'b0, es});
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},   {31'b0, imemReq},    32'd0);
      chk({tag, "_valid"}, {31'b0, instrValid}, 32'd0);
      chk({tag, "_instr"}, instr,               32'h0000_0013);
      chk({tag, "_pc"},    pc,                  32'h0);
      chk({tag, "_imm"},   {30'b0, immSrc},     32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      imemGnt    = 1'b1;
      redirect   = 1'b0;
      redirectPc = 32'h0;
      decReady   = 1'b1;
      lat2       = 1'b0;

      // Reset state, then streaming with 1-cycle memory.
      repeat (2) step();
      chk_reset_outputs("rst");
      rst = 1'b0;
      step();
      chk("p1_req",  {31'b0, imemReq}, 32'd1);
      chk("p1_addr", imemAddr, 32'h100);
      step();
      chk("p2_addr",  imemAddr, 32'h104);
      chk("p2_valid", {31'b0, instrValid}, 32'd0);
      step();
      chk("p3_addr",  imemAddr, 32'h108);
      chk("p3_pc",    pc, 32'h100);
      chk("p3_instr", instr, 32'h0000_8013);
      step();
      chk("p4_pc",    pc, 32'h104);
      chk("p4_instr", instr, 32'h0000_8213);
      chk("p4_addr",  imemAddr, 32'h10C);
      step();
      chk("p5_pc",    pc, 32'h108);
      chk("p5_instr", instr, 32'h0000_8413);
      chk("p5_addr",  imemAddr, 32'h110);

      // Decode stall: head held, fetch stops on credit.
      decReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", {31'b0, instrValid}, 32'd1);
         chk("stall_pc",    pc, 32'h108);
         chk("stall_instr", instr, 32'h0000_8413);
         chk("stall_req",   {31'b0, imemReq}, 32'd0);
      end
      decReady = 1'b1;
      #1;
      chk("rel_req",  {31'b0, imemReq}, 32'd1);
      chk("rel_addr", imemAddr, 32'h110);
      step();
      chk("rel1_pc", pc, 32'h10C);
      chk("rel1_instr", instr, 32'h0000_8613);
      step();
      chk("rel2_pc", pc, 32'h110);
      chk("rel2_instr", instr, 32'h0000_8813);

      // Mid-run reset, then 2-cycle memory.
      rst  = 1'b1;
      lat2 = 1'b1;
      step();
      chk_reset_outputs("rst2");
      rst = 1'b0;
      step();
      chk("q1_addr", imemAddr, 32'h100);
      step();
      chk("q2_req",  {31'b0, imemReq}, 32'd1);
      chk("q2_addr", imemAddr, 32'h104);
      step();
      chk("q3_req",  {31'b0, imemReq}, 32'd0);

      // Redirect with two responses outstanding (one arriving now).
      redirect   = 1'b1;
      redirectPc = 32'h0000_2002;
      step();
      redirect = 1'b0;
      #1;
      chk("r1_valid", {31'b0, instrValid}, 32'd0);
      chk("r1_req",   {31'b0, imemReq}, 32'd1);
      chk("r1_addr",  imemAddr, 32'h2000);
      step();
      chk("r2_valid", {31'b0, instrValid}, 32'd0);
      chk("r2_addr",  imemAddr, 32'h2004);
      step();
      chk("r3_valid", {31'b0, instrValid}, 32'd0);
      chk("r3_req",   {31'b0, imemReq}, 32'd0);
      step();
      chk("r4_valid", {31'b0, instrValid}, 32'd1);
      chk("r4_pc",    pc, 32'h2000);
      chk("r4_instr", instr, 32'h0010_0013);

      // Redirect coinciding with a response and a pop.
      redirect   = 1'b1;
      redirectPc = 32'h0000_0300;
      step();
      redirect = 1'b0;
      chk("s1_valid", {31'b0, instrValid}, 32'd0);
      chk("s1_instr", instr, 32'h0000_0013);
      chk("s1_pc",    pc, 32'h0);
      #1;
      chk("s1_req",   {31'b0, imemReq}, 32'd1);
      chk("s1_addr",  imemAddr, 32'h300);

      // Immediate class of successive heads.
      wait_head("imm0", 32'h300, 32'h00A0_0093, 2'b00);
      wait_head("imm1", 32'h304, 32'h0011_2023, 2'b01);
      wait_head("imm2", 32'h308, 32'h0000_0463, 2'b10);
      wait_head("imm3", 32'h30C, 32'h0080_006F, 2'b11);
      wait_head("imm4", 32'h310, 32'h0000_0037, 2'b00);

      // Drain memory, then redirect to the top of the address space.
      imemGnt = 1'b0;
      repeat (4) step();
      redirect   = 1'b1;
      redirectPc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      imemGnt  = 1'b1;
      #1;
      chk("w1_valid", {31'b0, instrValid}, 32'd0);
      chk("w1_req",   {31'b0, imemReq}, 32'd1);
      chk("w1_addr",  imemAddr, 32'hFFFF_FFFC);
      step();
      chk("w2_req",   {31'b0, imemReq}, 32'd1);
      chk("w2_addr",  imemAddr, 32'h0000_0000);
      wait_head("wrap0", 32'hFFFF_FFFC, 32'hFFFF_FE13, 2'b00);
      wait_head("wrap1", 32'h0000_0000, 32'h0000_0013, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC core. Holds the fetch PC, issues in-order requests to instruction memory over a request/grant + response-valid handshake, and buffers up to two returned instructions with their PCs in a 2-entry FIFO. It presents the oldest instruction, its PC and a pre-decoded `immSrc` to the decode stage, where the immediate extender consumes them. It also accepts branch/jump redirects and discards in-flight stale responses.

## Interface
- `RESET_PC`, 32'h00000000: fetch address after reset; bits [1:0] ignored (forced 0).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imemReq` out 1: fetch request valid.
- `imemAddr` out 32: fetch address, word aligned.
- `imemGnt` in 1: request accepted this cycle (handshake = `imemReq & imemGnt`).
- `imemRvalid` in 1: response valid; responses in request order, earliest the cycle after grant.
- `imemRdata` in 32: instruction word.
- `redirect` in 1: flush and restart fetch at `redirectPc`.
- `redirectPc` in 32: new fetch address; bits [1:0] forced 0.
- `instrValid` out 1: FIFO head valid.
- `instr` out 32: head instruction; 32'h00000013 (NOP) when `instrValid`=0.
- `pc` out 32: head PC; 0 when `instrValid`=0.
- `immSrc` out 2: immediate class of head: 00 I, 01 S, 10 B, 11 J.
- `decReady` in 1: decode accepts head; pop = `instrValid & decReady`.

## Operation
- State: `fetchPc` (32), `respPc` (32, PC of next expected response), `outstanding` (0..2), `dropCount` (0..2), FIFO (2 × {pc, instr}), occupancy (0..2).
- Credit: `imemReq` = !`redirect` & (`outstanding` + occupancy − pop) < 2. `imemAddr` = `fetchPc`.
- Grant: `fetchPc` += 4 (wraps mod 2^32), `outstanding` += 1.
- Response with `dropCount`>0: discarded, `dropCount` −= 1, `outstanding` −= 1.
- Response with `dropCount`=0: push {`respPc`, `imemRdata`}, `respPc` += 4, `outstanding` −= 1.
- Simultaneous push and pop legal at any occupancy; credit guarantees no overflow. Never pop when empty.
- Redirect (priority over everything else in that cycle): `fetchPc` and `respPc` <= `redirectPc` & ~3; FIFO cleared (a same-cycle pop is ignored); no request issued; a same-cycle response is discarded; `dropCount` <= `outstanding` after that cycle's response retirement.
- `immSrc` decode of `instr[6:0]`: 0100011 → 01; 1100011 → 10; 1101111 → 11; all others (incl. 0000011, 0010011, 1100111, empty) → 00.
- Reset: `fetchPc`/`respPc` = `RESET_PC`, counters 0, FIFO empty. Outputs: `imemReq` 0, `instrValid` 0, `instr` 32'h00000013, `pc` 0, `immSrc` 00. Reset mid-transaction abandons all responses; the memory side is reset by the same `rst`.

## Timing
- First `imemReq` in the first cycle after `rst` deasserts, `imemAddr` = `RESET_PC`.
- Latency: grant at N, response at N+1 (earliest), `instrValid` at N+2 (registered FIFO).
- Throughput: one instruction per cycle sustained with 1-cycle memory latency and `decReady` held at 1.
- Redirect at cycle R: `instrValid`=0 at R+1; `imemReq` at R+1 with `imemAddr` = `redirectPc`.
- `decReady`=0: the head is held stable (instr, pc, immSrc unchanged). Fetch stops once credits reach 2.
- All outputs except `imemReq`, `imemAddr` and `immSrc` come directly from registers.

## Test plan
- Reset release with `RESET_PC`=0x100 and 1-cycle memory: requests at 0x100, 0x104, 0x108 on consecutive cycles; `pc`/`instr` pairs emerge in order, one per cycle.
- `decReady`=0 for 5 cycles: occupancy plus outstanding never exceeds 2; head held stable; order preserved with no loss after release.
- Redirect to 0x2002 while 2 responses are outstanding: both responses dropped; next `imemAddr`=0x2000; first valid `pc`=0x2000.
- Redirect in the same cycle as a response and a pop: FIFO empty at R+1; no stale instruction ever appears.
- `immSrc` check: heads 0x00A00093 → 00, 0x00112023 → 01, 0x00000463 → 10, 0x0080006F → 11, 0x00000037 → 00.
- Wrap: redirect to 0xFFFFFFFC: next requests at 0xFFFFFFFC then 0x00000000.
